// File: rtl/regfile_write_scheduler_pkg.sv
// regfile_write_scheduler_pkg: shared widths, zero-register address and writeback request type
package regfile_write_scheduler_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int NUM_REGS = 1 << REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;
endpackage

// File: rtl/regfile_write_scheduler_fifo.sv
// wb_fifo: small power-of-two FIFO of writeback requests with occupancy count
module wb_fifo
   import regfile_write_scheduler_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    push_i,
   input  logic    pop_i,
   input  wb_req_t din_i,
   output wb_req_t dout_o,
   output logic    full_o,
   output logic    empty_o
);
   localparam int AW = $clog2(DEPTH);
   wb_req_t mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] cnt_q;
   assign dout_o = mem_q[rd_q];
   assign full_o = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   // storage is not reset: only entries below the count are ever read
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end
   // pointers wrap naturally at DEPTH; simultaneous push and pop leaves the count unchanged
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_q + AW'(push_i);
         rd_q <= rd_q + AW'(pop_i);
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end
endmodule

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: merges ALU and load writebacks onto one RF write port with a busy scoreboard
module regfile_write_scheduler
   import regfile_write_scheduler_pkg::wb_req_t, regfile_write_scheduler_pkg::REG_ADDR_W,
          regfile_write_scheduler_pkg::DATA_W, regfile_write_scheduler_pkg::NUM_REGS;
#(
   parameter int FIFO_DEPTH = 2,
   parameter logic [REG_ADDR_W-1:0] ZERO_REG = regfile_write_scheduler_pkg::ZERO_REG
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [REG_ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0]     a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [REG_ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0]     b_data,
   input  logic                  rsv_valid,
   input  logic [REG_ADDR_W-1:0] rsv_addr,
   input  logic [REG_ADDR_W-1:0] chk_addr1,
   input  logic [REG_ADDR_W-1:0] chk_addr2,
   output logic                  chk_busy1,
   output logic                  chk_busy2,
   output logic [NUM_REGS-1:0]   busy_vec,
   output logic                  rf_write_enable,
   output logic [REG_ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0]     rf_write_data
);
   wb_req_t a_in, b_in, a_head, b_head, head;
   logic a_full, a_empty, b_full, b_empty, a_push, b_push, grant_a, grant_b, pop;
   logic prefer_b_q, prefer_b_d;
   logic rf_we_q;
   logic [REG_ADDR_W-1:0] rf_addr_q;
   logic [DATA_W-1:0] rf_data_q;
   logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;
   assign a_ready = !a_full && !rst;
   assign b_ready = !b_full && !rst;
   assign a_push = a_valid && a_ready;
   assign b_push = b_valid && b_ready;
   assign a_in = '{addr: a_addr, data: a_data};
   assign b_in = '{addr: b_addr, data: b_data};
   assign busy_vec = busy_q;
   assign chk_busy1 = busy_q[chk_addr1];
   assign chk_busy2 = busy_q[chk_addr2];
   assign rf_write_enable = rf_we_q;
   assign rf_write_addr = rf_addr_q;
   assign rf_write_data = rf_data_q;
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
      .clk_i(clk), .rst_i(rst), .push_i(a_push), .pop_i(grant_a),
      .din_i(a_in), .dout_o(a_head), .full_o(a_full), .empty_o(a_empty)
   );
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
      .clk_i(clk), .rst_i(rst), .push_i(b_push), .pop_i(grant_b),
      .din_i(b_in), .dout_o(b_head), .full_o(b_full), .empty_o(b_empty)
   );
   // round-robin grant; the pointer only moves when both heads compete
   always_comb begin
      grant_a = !a_empty && (b_empty || !prefer_b_q);
      grant_b = !b_empty && !grant_a;
      pop = grant_a || grant_b;
      head = grant_a ? a_head : b_head;
      prefer_b_d = (!a_empty && !b_empty) ? grant_a : prefer_b_q;
   end
   // scoreboard next state: a new reservation beats the clear of the write landing this cycle
   always_comb begin
      set_mask = (rsv_valid && rsv_addr != ZERO_REG) ? NUM_REGS'(1) << rsv_addr : '0;
      clr_mask = rf_we_q ? NUM_REGS'(1) << rf_addr_q : '0;
      busy_d = ((busy_q & ~clr_mask) | set_mask) & ~(NUM_REGS'(1) << ZERO_REG);
   end
   // arbiter pointer, registered write port and scoreboard state
   always_ff @(posedge clk) begin
      if (rst) begin
         prefer_b_q <= 1'b0;
         rf_we_q <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         busy_q <= '0;
      end else begin
         prefer_b_q <= prefer_b_d;
         busy_q <= busy_d;
         rf_we_q <= pop && head.addr != ZERO_REG;
         if (pop) begin
            rf_addr_q <= head.addr;
            rf_data_q <= head.data;
         end
      end
   end
endmodule
